// File: rtl/cfg_wr_pkg.sv
// cfg_wr_pkg
//   Shared definitions for the configuration write controller:
//   FSM state encoding and bit positions inside the wr_leds status bus.
package cfg_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_CHECK = 3'd2,
    ST_LOAD  = 3'd3,
    ST_ERROR = 3'd4
  } cfg_wr_state_e;

  localparam int LED_BUSY = 0;  // mirrors busy
  localparam int LED_OK   = 1;  // last session committed (sticky)
  localparam int LED_ERR  = 2;  // last session aborted (sticky)

endpackage

// File: rtl/cfg_wr_timer.sv
// cfg_wr_timer
//   Idle-gap counter for a write session. Counts enabled cycles since the
//   last clear and flags the cycle in which the TIMEOUT_CYC-th consecutive
//   enabled cycle is being completed, so the controller can leave on that
//   same edge.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous, active-high reset
//   clear   in  restart the count from zero
//   enable  in  count this cycle as idle
//   expired out high while the current enabled cycle is the TIMEOUT_CYC-th
module cfg_wr_timer
  import cfg_wr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != TW'(TIMEOUT_CYC))) begin
      // saturates rather than wrapping; the FSM leaves before this matters
      cnt <= cnt + TW'(1);
    end
  end

  // cnt already holds TIMEOUT_CYC-1 idle cycles; this one is the last allowed
  assign expired = enable && (cnt == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cfg_write_ctrl.sv
// cfg_write_ctrl
//   Receives NUM_REGS configuration bytes from a UART-style byte stream into
//   a shadow array, optionally verifies a trailing XOR checksum, and commits
//   the shadow to cfg_data in one step. Sessions abort on checksum mismatch
//   or when the stream goes idle for TIMEOUT_CYC cycles.
// Ports:
//   clk, rst            clock / synchronous active-high reset
//   start_wr            arms a session (sampled in IDLE only)
//   rx_valid, rx_data   one-cycle byte strobe and data
//   cfg_data            committed registers, reg i at [i*DATA_W +: DATA_W]
//   load_cfg, done_wr   one-cycle pulse on successful commit
//   err_wr              one-cycle pulse on aborted session
//   busy                high outside IDLE
//   wr_leds             {last error, last ok, busy}
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_wr; rx_valid ignored
// RECV     | collecting data bytes into the shadow array
// CHECK    | waiting for the checksum byte
// LOAD     | one cycle, shadow committed, load_cfg/done_wr high
// ERROR    | one cycle, err_wr high, cfg_data untouched
module cfg_write_ctrl
  import cfg_wr_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 12,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int CHK_EN      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_wr,
  input  logic                         rx_valid,
  input  logic [DATA_W-1:0]            rx_data,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_data,
  output logic                         load_cfg,
  output logic                         done_wr,
  output logic                         err_wr,
  output logic                         busy,
  output logic [2:0]                   wr_leds
);

  localparam int CNT_W = $clog2(NUM_REGS + 1);

  cfg_wr_state_e               state;
  logic [CNT_W-1:0]            count;
  logic [DATA_W-1:0]           csum;
  logic [DATA_W-1:0]           shadow [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0]  shadow_merged;
  logic                        led_ok;
  logic                        led_err;
  logic                        in_session;
  logic                        last_byte;
  logic                        timer_clear;
  logic                        timer_en;
  logic                        timer_expired;

  assign in_session  = (state == ST_RECV) || (state == ST_CHECK);
  assign last_byte   = (count == CNT_W'(NUM_REGS - 1));
  assign timer_clear = (state == ST_IDLE) || (in_session && rx_valid);
  assign timer_en    = in_session && !rx_valid;

  cfg_wr_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // Shadow contents with the byte being accepted this cycle folded in, so the
  // commit without a checksum can happen on the same edge as the last byte.
  always_comb begin
    shadow_merged = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      shadow_merged[i*DATA_W +: DATA_W] = shadow[i];
      if ((state == ST_RECV) && rx_valid && (count == CNT_W'(i))) begin
        shadow_merged[i*DATA_W +: DATA_W] = rx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      csum     <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
      cfg_data <= '0;
      load_cfg <= 1'b0;
      done_wr  <= 1'b0;
      err_wr   <= 1'b0;
      busy     <= 1'b0;
      led_ok   <= 1'b0;
      led_err  <= 1'b0;
    end else begin
      load_cfg <= 1'b0;
      done_wr  <= 1'b0;
      err_wr   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_wr) begin
            state   <= ST_RECV;
            busy    <= 1'b1;
            count   <= '0;
            csum    <= '0;
            led_ok  <= 1'b0;
            led_err <= 1'b0;
          end
        end
        ST_RECV: begin
          if (rx_valid) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (count == CNT_W'(i)) shadow[i] <= rx_data;
            end
            csum  <= csum ^ rx_data;
            count <= count + CNT_W'(1);
            if (last_byte) begin
              if (CHK_EN != 0) begin
                state <= ST_CHECK;
              end else begin
                state    <= ST_LOAD;
                cfg_data <= shadow_merged;
                load_cfg <= 1'b1;
                done_wr  <= 1'b1;
                led_ok   <= 1'b1;
              end
            end
          end else if (timer_expired) begin
            state   <= ST_ERROR;
            err_wr  <= 1'b1;
            led_err <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              state    <= ST_LOAD;
              cfg_data <= shadow_merged;
              load_cfg <= 1'b1;
              done_wr  <= 1'b1;
              led_ok   <= 1'b1;
            end else begin
              state   <= ST_ERROR;
              err_wr  <= 1'b1;
              led_err <= 1'b1;
            end
          end else if (timer_expired) begin
            state   <= ST_ERROR;
            err_wr  <= 1'b1;
            led_err <= 1'b1;
          end
        end
        ST_LOAD, ST_ERROR: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_leds[LED_BUSY] = busy;
  assign wr_leds[LED_OK]   = led_ok;
  assign wr_leds[LED_ERR]  = led_err;

endmodule

// File: tb/tb_cfg_write_ctrl.sv
// tb_cfg_write_ctrl
//   Two controller instances share clk/rst: index 0 checks a trailing XOR
//   checksum, index 1 has no checksum. Each session is described as byte
//   values plus idle gaps; the expected outcome (commit or abort, pulse
//   cycle, committed word, status bits) is worked out from those rules.
module tb_cfg_write_ctrl;

  localparam int NR = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_i   [2];
  logic        rv_i   [2];
  logic [7:0]  rd_i   [2];
  logic [31:0] cfg_o  [2];
  logic        load_o [2];
  logic        done_o [2];
  logic        err_o  [2];
  logic        busy_o [2];
  logic [2:0]  leds_o [2];

  always #5 clk = ~clk;

  cfg_write_ctrl #(.DATA_W(8), .NUM_REGS(NR), .TIMEOUT_CYC(TO), .CHK_EN(1)) dut_chk (
    .clk(clk), .rst(rst), .start_wr(sw_i[0]), .rx_valid(rv_i[0]), .rx_data(rd_i[0]),
    .cfg_data(cfg_o[0]), .load_cfg(load_o[0]), .done_wr(done_o[0]), .err_wr(err_o[0]),
    .busy(busy_o[0]), .wr_leds(leds_o[0]));

  cfg_write_ctrl #(.DATA_W(8), .NUM_REGS(NR), .TIMEOUT_CYC(TO), .CHK_EN(0)) dut_raw (
    .clk(clk), .rst(rst), .start_wr(sw_i[1]), .rx_valid(rv_i[1]), .rx_data(rd_i[1]),
    .cfg_data(cfg_o[1]), .load_cfg(load_o[1]), .done_wr(done_o[1]), .err_wr(err_o[1]),
    .busy(busy_o[1]), .wr_leds(leds_o[1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Pulse monitor: monotonic counters, read as differences by the tasks.
  int load_cnt [2];
  int load_last[2];
  int err_cnt  [2];
  int err_last [2];
  int done_bad [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      load_cnt[k] = 0; load_last[k] = -1; err_cnt[k] = 0; err_last[k] = -1; done_bad[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (load_o[k] === 1'b1) begin
        load_cnt[k]  <= load_cnt[k] + 1;
        load_last[k] <= cyc;
      end
      if (err_o[k] === 1'b1) begin
        err_cnt[k]  <= err_cnt[k] + 1;
        err_last[k] <= cyc;
      end
      if (done_o[k] !== load_o[k]) done_bad[k] <= done_bad[k] + 1;
    end
  end

  // Reference state
  logic [31:0] exp_cfg   [2];
  logic [1:0]  exp_stick [2];  // {error, ok}

  // Session description
  logic [7:0] s_bytes [8];
  int         s_gaps  [8];
  int         s_len;
  bit         s_start_rx;
  bit         s_idle_start;

  // Flattened per-cycle schedule
  logic       sch_v [256];
  logic       sch_s [256];
  logic [7:0] sch_d [256];
  int         sch_n;
  bit         sch_to;

  task automatic step(input int k, input logic sw, input logic v, input logic [7:0] d,
                      output int en);
    @(posedge clk); #1;
    sw_i[k] = sw;
    rv_i[k] = v;
    rd_i[k] = d;
    en = cyc + 1;  // edge that samples these values
  endtask

  task automatic clear_session();
    for (int i = 0; i < 8; i++) s_gaps[i] = 0;
    s_start_rx   = 1'b0;
    s_idle_start = 1'b0;
  endtask

  task automatic run_session(input int k, input string name);
    int          e, last_e, g, lb, eb, db;
    logic [7:0]  x;
    logic [31:0] new_cfg;
    bit          ok;
    sch_n = 0; sch_to = 1'b0; x = '0; new_cfg = exp_cfg[k]; last_e = 0;
    for (int i = 0; i < s_len; i++) begin
      g = (s_gaps[i] >= TO) ? TO : s_gaps[i];
      for (int j = 0; j < g; j++) begin
        sch_v[sch_n] = 1'b0; sch_s[sch_n] = s_idle_start; sch_d[sch_n] = 8'($urandom);
        sch_n++;
      end
      if (s_gaps[i] >= TO) begin
        sch_to = 1'b1;
        break;
      end
      sch_v[sch_n] = 1'b1; sch_s[sch_n] = 1'b0; sch_d[sch_n] = s_bytes[i];
      sch_n++;
      if (i < NR) begin
        new_cfg[i*8 +: 8] = s_bytes[i];
        x ^= s_bytes[i];
      end
    end
    ok = !sch_to && ((k == 1) || (s_bytes[NR] == x));

    @(posedge clk); #1;
    total++;
    if (busy_o[k] !== 1'b0 || leds_o[k] !== {exp_stick[k], 1'b0}) begin
      bad++;
      $display("FAIL %s idle_status dut%0d: got busy=%b leds=%b, want busy=0 leds=%b",
               name, k, busy_o[k], leds_o[k], {exp_stick[k], 1'b0});
    end
    lb = load_cnt[k]; eb = err_cnt[k]; db = done_bad[k];
    sw_i[k] = 1'b1; rv_i[k] = s_start_rx; rd_i[k] = 8'hEE;

    for (int j = 0; j < sch_n; j++) begin
      step(k, sch_s[j], sch_v[j], sch_d[j], e);
      last_e = e;
      if (j == 0) begin
        total++;
        if (leds_o[k] !== 3'b001) begin
          bad++;
          $display("FAIL %s armed_leds dut%0d: got %b want 001", name, k, leds_o[k]);
        end
      end
    end
    step(k, 1'b0, 1'b0, 8'h00, e);
    @(negedge clk); #1;

    if (ok) begin
      total++;
      if (load_cnt[k] - lb !== 1 || load_last[k] !== last_e) begin
        bad++;
        $display("FAIL %s load_pulse dut%0d: got n=%0d at %0d, want n=1 at %0d",
                 name, k, load_cnt[k] - lb, load_last[k], last_e);
      end
      total++;
      if (err_cnt[k] - eb !== 0) begin
        bad++;
        $display("FAIL %s no_err dut%0d: got %0d err pulses want 0", name, k, err_cnt[k] - eb);
      end
      total++;
      if (done_bad[k] - db !== 0) begin
        bad++;
        $display("FAIL %s done_vs_load dut%0d: got %0d differing cycles want 0",
                 name, k, done_bad[k] - db);
      end
      total++;
      if (cfg_o[k] !== new_cfg) begin
        bad++;
        $display("FAIL %s cfg dut%0d: got %h want %h", name, k, cfg_o[k], new_cfg);
      end
      total++;
      if (leds_o[k] !== 3'b011) begin
        bad++;
        $display("FAIL %s load_leds dut%0d: got %b want 011", name, k, leds_o[k]);
      end
      exp_cfg[k]   = new_cfg;
      exp_stick[k] = 2'b01;
    end else begin
      total++;
      if (err_cnt[k] - eb !== 1 || err_last[k] !== last_e) begin
        bad++;
        $display("FAIL %s err_pulse dut%0d: got n=%0d at %0d, want n=1 at %0d",
                 name, k, err_cnt[k] - eb, err_last[k], last_e);
      end
      total++;
      if (load_cnt[k] - lb !== 0) begin
        bad++;
        $display("FAIL %s no_load dut%0d: got %0d load pulses want 0", name, k, load_cnt[k] - lb);
      end
      total++;
      if (cfg_o[k] !== exp_cfg[k]) begin
        bad++;
        $display("FAIL %s cfg_held dut%0d: got %h want %h", name, k, cfg_o[k], exp_cfg[k]);
      end
      total++;
      if (leds_o[k] !== 3'b101) begin
        bad++;
        $display("FAIL %s err_leds dut%0d: got %b want 101", name, k, leds_o[k]);
      end
      exp_stick[k] = 2'b10;
    end
  endtask

  task automatic fill_random(input int k, input bit gap0);
    logic [7:0] x;
    int r;
    x = '0;
    s_len = (k == 0) ? NR + 1 : NR;
    for (int i = 0; i < NR; i++) begin
      s_bytes[i] = 8'($urandom);
      x ^= s_bytes[i];
    end
    s_bytes[NR] = x;
    if ($urandom_range(0, 2) == 0) s_bytes[NR] = x ^ 8'($urandom_range(1, 255));
    for (int i = 0; i < s_len; i++) begin
      r = int'($urandom_range(0, 9));
      if (gap0 || r < 6)  s_gaps[i] = 0;
      else if (r < 9)     s_gaps[i] = int'($urandom_range(1, TO - 1));
      else                s_gaps[i] = int'($urandom_range(TO, TO + 2));
    end
    s_start_rx   = 1'($urandom_range(0, 1));
    s_idle_start = 1'($urandom_range(0, 1));
  endtask

  task automatic check_all_zero(input string name);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({load_o[k], done_o[k], err_o[k], busy_o[k]} !== 4'b0000) begin
        bad++;
        $display("FAIL %s pulses dut%0d: got %b want 0000", name, k,
                 {load_o[k], done_o[k], err_o[k], busy_o[k]});
      end
      total++;
      if (cfg_o[k] !== 32'h0 || leds_o[k] !== 3'b000) begin
        bad++;
        $display("FAIL %s cfg_leds dut%0d: got cfg=%h leds=%b want 0/000",
                 name, k, cfg_o[k], leds_o[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_release");
    for (int k = 0; k < 2; k++) begin
      exp_cfg[k] = '0; exp_stick[k] = 2'b00;
    end
  endtask

  task automatic test_bad_checksum();
    clear_session();
    s_len = 5;
    s_bytes[0] = 8'h11; s_bytes[1] = 8'h22; s_bytes[2] = 8'h33; s_bytes[3] = 8'h44;
    s_bytes[4] = 8'h45;
    run_session(0, "bad_checksum");
    total++;
    if (cfg_o[0] !== 32'h0) begin
      bad++;
      $display("FAIL bad_checksum cfg_zero: got %h want 00000000", cfg_o[0]);
    end
  endtask

  task automatic test_good();
    int e;
    clear_session();
    s_len = 5;
    s_bytes[0] = 8'h11; s_bytes[1] = 8'h22; s_bytes[2] = 8'h33; s_bytes[3] = 8'h44;
    s_bytes[4] = 8'h44;
    run_session(0, "good");
    total++;
    if (cfg_o[0] !== 32'h44332211) begin
      bad++;
      $display("FAIL good cfg_word: got %h want 44332211", cfg_o[0]);
    end
    step(0, 1'b0, 1'b0, 8'h00, e);
    total++;
    if (leds_o[0] !== 3'b010 || busy_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL good final_leds: got leds=%b busy=%b want 010/0", leds_o[0], busy_o[0]);
    end
  endtask

  task automatic test_no_checksum();
    clear_session();
    s_len = 4;
    s_bytes[0] = 8'h01; s_bytes[1] = 8'h02; s_bytes[2] = 8'h03; s_bytes[3] = 8'h04;
    run_session(1, "no_checksum");
    total++;
    if (cfg_o[1] !== 32'h04030201) begin
      bad++;
      $display("FAIL no_checksum cfg_word: got %h want 04030201", cfg_o[1]);
    end
  endtask

  task automatic test_timeout();
    clear_session();
    s_len = 5;
    s_bytes[0] = 8'hAA; s_bytes[1] = 8'hBB;
    s_gaps[2]  = TO;
    run_session(0, "timeout");
    // longest legal gap, just under the limit, must not abort
    clear_session();
    s_len = 5;
    s_bytes[0] = 8'h5C; s_bytes[1] = 8'h0F; s_bytes[2] = 8'hE1; s_bytes[3] = 8'h77;
    s_bytes[4] = 8'h5C ^ 8'h0F ^ 8'hE1 ^ 8'h77;
    s_gaps[0] = TO - 1; s_gaps[4] = TO - 1;
    run_session(0, "timeout_edge");
  endtask

  task automatic test_ignore();
    int e, lb, eb;
    lb = load_cnt[0]; eb = err_cnt[0];
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 8'($urandom), e);
    step(0, 1'b0, 1'b0, 8'h00, e);
    @(negedge clk); #1;
    total++;
    if (busy_o[0] !== 1'b0 || load_cnt[0] - lb !== 0 || err_cnt[0] - eb !== 0) begin
      bad++;
      $display("FAIL idle_rx busy=%b loads=%0d errs=%0d want 0/0/0",
               busy_o[0], load_cnt[0] - lb, err_cnt[0] - eb);
    end
    clear_session();
    s_len = 5;
    s_bytes[0] = 8'h9D; s_bytes[1] = 8'h42; s_bytes[2] = 8'h00; s_bytes[3] = 8'hFF;
    s_bytes[4] = 8'h9D ^ 8'h42 ^ 8'h00 ^ 8'hFF;
    s_gaps[4] = 3;
    s_start_rx = 1'b1;
    s_idle_start = 1'b1;
    run_session(0, "ignore");
  endtask

  task automatic test_mid_reset();
    int e, eb;
    eb = err_cnt[0];
    step(0, 1'b1, 1'b0, 8'h00, e);
    step(0, 1'b0, 1'b1, 8'h5A, e);
    step(0, 1'b0, 1'b1, 8'hA5, e);
    step(0, 1'b0, 1'b0, 8'h00, e);
    total++;
    if (busy_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset in_session: got busy=%b want 1", busy_o[0]);
    end
    // reset wins over a simultaneous start and byte
    rst = 1'b1; sw_i[0] = 1'b1; rv_i[0] = 1'b1; rd_i[0] = 8'h33;
    @(posedge clk); #1;
    rst = 1'b0; sw_i[0] = 1'b0; rv_i[0] = 1'b0;
    check_all_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (err_cnt[0] - eb !== 0 || busy_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset no_err: got errs=%0d busy=%b want 0/0", err_cnt[0] - eb, busy_o[0]);
    end
    for (int k = 0; k < 2; k++) begin
      exp_cfg[k] = '0; exp_stick[k] = 2'b00;
    end
    clear_session();
    s_len = 5;
    s_bytes[0] = 8'h12; s_bytes[1] = 8'h34; s_bytes[2] = 8'h56; s_bytes[3] = 8'h78;
    s_bytes[4] = 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78;
    run_session(0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 5; n++) begin
      fill_random(0, 1'b1);
      run_session(0, "back_to_back");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      fill_random(0, 1'b0);
      run_session(0, "random_chk");
    end
    for (int n = 0; n < 8; n++) begin
      fill_random(1, 1'b0);
      run_session(1, "random_raw");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      sw_i[k] = 1'b0; rv_i[k] = 1'b0; rd_i[k] = 8'h00;
      exp_cfg[k] = '0; exp_stick[k] = 2'b00;
    end
    test_reset();
    test_bad_checksum();
    test_good();
    test_no_checksum();
    test_timeout();
    test_ignore();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfg_write_ctrl.md
CFG_WRITE_CTRL -- requirements
Module: cfg_write_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of one received byte/register; legal values >= 1.
REQ-002 Parameter NUM_REGS, default 12: configuration registers per write session; legal values >= 1.
REQ-003 Parameter TIMEOUT_CYC, default 50000000: idle cycles allowed between accepted bytes; legal values >= 2.
REQ-004 Parameter CHK_EN, default 1: 1 means an XOR checksum byte follows the data bytes; 0 means no checksum.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start_wr  in  1  arms a write session when sampled high in IDLE.
REQ-008 rx_valid  in  1  one-cycle strobe, rx_data valid (UART rxrdy).
REQ-009 rx_data  in  DATA_W  received byte.
REQ-010 cfg_data  out  NUM_REGS*DATA_W  committed configuration; register i at bits [i*DATA_W +: DATA_W].
REQ-011 load_cfg  out  1  one-cycle pulse, cfg_data has been updated.
REQ-012 done_wr  out  1  one-cycle pulse, session completed successfully; coincident with load_cfg.
REQ-013 err_wr  out  1  one-cycle pulse, session aborted by checksum mismatch or timeout.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 wr_leds  out  3  status: bit0 = busy, bit1 = last session OK (sticky), bit2 = last session error (sticky).

Function
REQ-016 FSM states are IDLE, RECV, CHECK, LOAD and ERROR; load_cfg, done_wr, err_wr and busy are Moore outputs.
REQ-017 IDLE: when start_wr=1, go to RECV, clear byte count, timer and running checksum, and clear wr_leds[2:1]; rx_valid is ignored in IDLE, including in the start cycle.
REQ-018 RECV: each rx_valid writes rx_data into shadow register [count], XORs it into the checksum, increments count and clears the timer.
REQ-019 RECV: the rx_valid that accepts byte NUM_REGS-1 goes to CHECK if CHK_EN=1, else to LOAD.
REQ-020 CHECK: the next rx_valid goes to LOAD if rx_data equals the running checksum, else to ERROR.
REQ-021 LOAD lasts 1 cycle: load_cfg=1, done_wr=1, wr_leds[1] set; then return to IDLE.
REQ-022 cfg_data takes the shadow contents, including the final data byte, no later than the cycle in which load_cfg is high; otherwise cfg_data is held.
REQ-023 ERROR lasts 1 cycle: err_wr=1, wr_leds[2] set, cfg_data unchanged; then return to IDLE.
REQ-024 Timeout: in RECV/CHECK the timer increments on each cycle without rx_valid; on reaching TIMEOUT_CYC consecutive such cycles, go to ERROR.
REQ-025 start_wr while busy is ignored; rx_valid in LOAD or ERROR is dropped.
REQ-026 Back-to-back rx_valid on consecutive cycles shall all be accepted; sessions are contiguous with no gap requirement.
REQ-027 Latency: accepting the last byte (data byte if CHK_EN=0, checksum byte if CHK_EN=1) at edge k puts load_cfg high for exactly the cycle following edge k.
REQ-028 Count width is clog2(NUM_REGS+1); timer width is clog2(TIMEOUT_CYC+1); neither wraps within a session.

Reset
REQ-029 rst forces state IDLE and clears count, timer, checksum, shadow, cfg_data and wr_leds to 0.
REQ-030 All pulse outputs and busy are 0 during and immediately after reset.
REQ-031 rst mid-session aborts the session with no err_wr pulse and clears cfg_data to 0.
REQ-032 rst has priority over every other input in the same cycle.

Structure
REQ-033 Package cfg_wr_pkg holds the FSM state encoding and the wr_leds bit indices.
REQ-034 The idle-timeout counter is a sub-module cfg_wr_timer (ports: clk, rst, clear, enable, expired; parameter TIMEOUT_CYC).
REQ-035 The shadow register array is internal to cfg_write_ctrl; no other sub-modules.

Verification (NUM_REGS=4, DATA_W=8, TIMEOUT_CYC=16 unless stated)
REQ-036 CHK_EN=1, start, bytes 11,22,33,44, checksum 44 -> load_cfg and done_wr one cycle, cfg_data=0x44332211, wr_leds=010.
REQ-037 Same bytes, checksum 45 -> err_wr one cycle, no load_cfg, cfg_data stays 0, wr_leds=100.
REQ-038 Start, bytes AA,BB, then 16 idle cycles -> err_wr on the cycle after the 16th idle cycle, busy drops, a new session then succeeds.
REQ-039 rst asserted after 2 bytes -> all outputs 0 the next cycle, no err_wr; a following full session loads correctly.
REQ-040 rx_valid while IDLE and start_wr mid-RECV both ignored; 4 bytes on consecutive cycles all accepted.
REQ-041 CHK_EN=0, bytes 01,02,03,04 -> load_cfg the cycle after the 4th byte, cfg_data=0x04030201.
